// File: rtl/yutorina_bus_pkg.sv
// -----------------------------------------------------------------------------
// yutorina_bus_pkg
//   Shared definitions for the CPU-side bus master interface:
//   - bus_state_e          : FSM state encoding (IDLE, REQ, ACCESS, WAIT)
//   - READ / WRITE         : values of the rw / bus_rw direction bit
//   - ENABLE_ / DISABLE_   : levels of the active-low bus control signals
//   - DEFAULT_TIMEOUT_CYC  : default WAIT length before a timeout abort
// -----------------------------------------------------------------------------
package yutorina_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } bus_state_e;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Active-low control levels (bus_req_, bus_as_, bus_grnt_, bus_rdy_).
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYC = 15;

endpackage : yutorina_bus_pkg

// File: rtl/yutorina_bus_timer.sv
// -----------------------------------------------------------------------------
// yutorina_bus_timer
//   Clear/enable cycle counter used to bound the slave WAIT phase.
//   Only instantiated when YUTORINA_BUS_TIMEOUT_EN is defined.
//
// Parameters:
//   LIMIT    number of enabled cycles after which the timer expires (>= 1)
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   clr      in   clear the count to zero (has priority over en)
//   en       in   count this cycle
//   expired  out  high during the enabled cycle whose edge brings the count
//                 to LIMIT, i.e. the last cycle of the allowed window
// -----------------------------------------------------------------------------
module yutorina_bus_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != CNT_W'(LIMIT))) begin
            // Saturate at LIMIT so a stalled owner can never wrap the counter.
            count <= count + 1'b1;
        end
    end

    // Flag the cycle in which the count is about to reach LIMIT, so the owner
    // can act on the same edge the count reaches the limit.
    assign expired = en && (count == CNT_W'(LIMIT - 1));

endmodule : yutorina_bus_timer

// File: rtl/yutorina_bus_if.sv
// -----------------------------------------------------------------------------
// yutorina_bus_if
//   CPU-side bus master. Turns a single-word load/store request into one bus
//   transaction: request the bus (REQ), strobe the address for one cycle
//   (ACCESS), wait for the slave ready (WAIT), then pulse ack for one cycle
//   back in IDLE.
//
// Optional feature: define YUTORINA_BUS_TIMEOUT_EN to abort a WAIT phase that
//   lasts TIMEOUT_CYC cycles without bus_rdy_; the abort completes with
//   ack=1, err=1, rd_data=0. Without the macro, WAIT never times out and err
//   is tied low.
//
// Handshake: req is sampled only in IDLE; once taken, the request fields are
//   latched and the CPU sees busy=1 until the ack cycle (busy=0, ack=1). A
//   request held high in the ack cycle is taken immediately (back-to-back).
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req            CPU access request (sampled only in IDLE)
//   rw             0 = read, 1 = write
//   addr           word address
//   wr_data        store data
//   rd_data        registered load data (holds until the next read completes)
//   ack            one-cycle completion pulse
//   err            completion was a timeout abort (valid with ack)
//   busy           transaction in progress
//   bus_req_       arbiter request, active-low
//   bus_grnt_      arbiter grant, active-low
//   bus_as_        address strobe, active-low, one cycle in ACCESS
//   bus_rw         bus direction
//   bus_addr       bus address (0 outside ACCESS/WAIT for OR-muxing)
//   bus_wr_data    bus write data (0 outside ACCESS/WAIT for OR-muxing)
//   bus_rd_data    slave read data
//   bus_rdy_       slave ready, active-low
//   state_dbg      current FSM state, for observation only
// -----------------------------------------------------------------------------
module yutorina_bus_if
    import yutorina_bus_pkg::*;
#(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    output bus_state_e        state_dbg
);

    bus_state_e        state;
    bus_state_e        state_next;

    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wr_data;

    logic              done;       // WAIT finishes at this edge
    logic              timed_out;  // ... and it finishes by abort
    logic              drive_bus;  // bus address/data phase active

    // -------------------------------------------------------------------------
    // Optional WAIT timeout
    // -------------------------------------------------------------------------
`ifdef YUTORINA_BUS_TIMEOUT_EN
    logic tmr_expired;

    // ACCESS is always followed by WAIT, so clearing in ACCESS starts every
    // WAIT phase from zero.
    yutorina_bus_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ST_ACCESS),
        .en      (state == ST_WAIT),
        .expired (tmr_expired)
    );

    // A ready seen on the limit edge wins over the abort.
    assign timed_out = (state == ST_WAIT) && (bus_rdy_ == DISABLE_) && tmr_expired;
`else
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = (TIMEOUT_CYC != 0);
    assign timed_out          = 1'b0;
`endif

    assign done = (state == ST_WAIT) && ((bus_rdy_ == ENABLE_) || timed_out);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. Grant is only looked at in REQ; ready only in WAIT.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_grnt_ == ENABLE_) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latch, completion pulse and load data
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_rw      <= READ;
            lat_addr    <= '0;
            lat_wr_data <= '0;
            rd_data     <= '0;
            ack         <= 1'b0;
            err         <= 1'b0;
        end else begin
            ack <= done;
            err <= timed_out;

            if ((state == ST_IDLE) && req) begin
                lat_rw      <= rw;
                lat_addr    <= addr;
                lat_wr_data <= wr_data;
            end

            if (timed_out) begin
                rd_data <= '0;
            end else if (done && (lat_rw != WRITE)) begin
                rd_data <= bus_rd_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Bus and CPU-side outputs, decoded from state
    // -------------------------------------------------------------------------
    assign drive_bus = (state == ST_ACCESS) || (state == ST_WAIT);

    // Request stays asserted from REQ until completion, regardless of grant.
    assign busy        = (state != ST_IDLE);
    assign bus_req_    = busy ? ENABLE_ : DISABLE_;
    assign bus_as_     = (state == ST_ACCESS) ? ENABLE_ : DISABLE_;
    assign bus_rw      = drive_bus ? lat_rw      : READ;
    assign bus_addr    = drive_bus ? lat_addr    : '0;
    assign bus_wr_data = drive_bus ? lat_wr_data : '0;
    assign state_dbg   = state;

endmodule : yutorina_bus_if

// File: tb/tb_yutorina_bus_if.sv
// -----------------------------------------------------------------------------
// tb_yutorina_bus_if
//   Bench for yutorina_bus_if. The driver plays both the CPU and the
//   arbiter/slave side, one cycle at a time. For each issued request it
//   pushes the expected completion (ack cycle, err, rd_data) into exp_q; an
//   independent monitor pops and compares whenever ack is seen.
//   Expected ack cycle = request-sampling cycle + 3 + grant waits + slave waits;
//   expected rd_data follows the "last completed read" rule.
// -----------------------------------------------------------------------------
module tb_yutorina_bus_if;
    import yutorina_bus_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 15;
    // {ack cycle, err, rd_data}
    localparam int EXP_W = 32 + 1 + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          req = 1'b0;
    logic          rw = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          ack, err, busy;
    logic          bus_req_;
    logic          bus_grnt_ = 1'b1;
    logic          bus_as_;
    logic          bus_rw;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_rd_data = '0;
    logic          bus_rdy_ = 1'b1;
    bus_state_e    state_dbg;

    yutorina_bus_if #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rw          (rw),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .ack         (ack),
        .err         (err),
        .busy        (busy),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic [DW-1:0]    model_rd = '0;   // rd_data the CPU should currently see
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 128'(ack), 128'(0));
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                check("ack_cycle", 128'(cyc), 128'(e[EXP_W-1 -: 32]));
                check("ack_err", 128'(err), 128'(e[DW]));
                check("ack_rd_data", 128'(rd_data), 128'(e[DW-1:0]));
                check("ack_cycle_idle", 128'({busy, bus_req_, bus_as_}), 128'(3'b011));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_bus(input string name);
        check(name, 128'({bus_req_, bus_as_, busy, bus_rw, bus_addr, bus_wr_data}),
              128'({1'b1, 1'b1, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}}));
    endtask

    task automatic check_reset_vals;
        check_idle_bus("reset_bus");
        check("reset_cpu", 128'({rd_data, ack, err}), 128'({{DW{1'b0}}, 1'b0, 1'b0}));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        model_rd = '0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle_bus("idle_bus");
            next_cycle();
        end
    endtask

    // Present the request; returns after the sampling edge with its cycle number.
    task automatic start_req(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int k);
        req = 1'b1; rw = r; addr = a; wr_data = d;
        next_cycle();
        k = cyc;
        // Scramble the CPU fields so only the latched copy can reach the bus.
        req = 1'b0; rw = 1'($urandom); addr = AW'($urandom); wr_data = $urandom;
    endtask

    // g cycles without grant, then one REQ cycle with grant.
    task automatic grant_phase(input int g);
        for (int i = 0; i <= g; i++) begin
            bus_grnt_ = (i == g) ? 1'b0 : 1'b1;
            @(negedge clk);
            check("req_phase", 128'({bus_req_, bus_as_, busy, bus_rw, bus_addr, bus_wr_data}),
                  128'({1'b0, 1'b1, 1'b1, 1'b0, {AW{1'b0}}, {DW{1'b0}}}));
            next_cycle();
        end
    endtask

    task automatic access_phase(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input bit spur);
        if (spur) bus_rdy_ = 1'b0;
        @(negedge clk);
        check("access_phase", 128'({bus_req_, bus_as_, busy, bus_rw, bus_addr, bus_wr_data}),
              128'({1'b0, 1'b0, 1'b1, r, a, d}));
        next_cycle();
        bus_rdy_ = 1'b1;
    endtask

    task automatic wait_cycle(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        check("wait_phase", 128'({bus_req_, bus_as_, busy, bus_rw, bus_addr, bus_wr_data}),
              128'({1'b0, 1'b1, 1'b1, r, a, d}));
        next_cycle();
    endtask

    // Full transaction. g grant waits, w slave waits before rdy_. abort >= 0
    // pulses rst in that WAIT cycle instead of completing. Returns at the ack
    // cycle, so a following call gives a back-to-back request.
    task automatic do_txn(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] rdv, input int g, input int w,
                          input bit spur, input bit drop, input int abort);
        int k;
        logic [DW-1:0] exp_rd;
        start_req(r, a, d, k);
        exp_rd = (r == WRITE) ? model_rd : rdv;
        if (abort < 0) exp_q.push_back({32'(k + 3 + g + w), 1'b0, exp_rd});
        grant_phase(g);
        access_phase(r, a, d, spur);
        if (drop) bus_grnt_ = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (i == abort) begin
                do_reset(1);
                bus_grnt_ = 1'b1;
                return;
            end
            wait_cycle(r, a, d);
        end
        bus_rdy_ = 1'b0;
        bus_rd_data = (r == WRITE) ? $urandom : rdv;
        wait_cycle(r, a, d);
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; bus_rd_data = $urandom;
        model_rd = exp_rd;
    endtask

    // Slave never answers.
    task automatic do_stuck(input logic [AW-1:0] a);
        int k;
        start_req(READ, a, '0, k);
        grant_phase(0);
        access_phase(READ, a, '0, 1'b0);
`ifdef YUTORINA_BUS_TIMEOUT_EN
        exp_q.push_back({32'(k + 2 + TO), 1'b1, {DW{1'b0}}});
        for (int i = 0; i < TO; i++) wait_cycle(READ, a, '0);
        bus_grnt_ = 1'b1;
        model_rd = '0;
`else
        for (int i = 0; i < 40; i++) wait_cycle(READ, a, '0);
        do_reset(1);
        bus_grnt_ = 1'b1;
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset(2);
        idle(2);

        // zero-wait ROM read, grant immediate
        do_txn(READ, 30'h100, 32'h0, 32'h12345678, 0, 0, 1'b0, 1'b0, -1);
        idle(2);
        // write with three slave wait cycles; rd_data must keep 0x12345678
        do_txn(WRITE, 30'h10, 32'hDEADBEEF, 32'h0, 0, 3, 1'b0, 1'b0, -1);
        idle(1);
        // delayed grant, then back-to-back request in the ack cycle
        do_txn(READ, 30'h2000, 32'h0, 32'hCAFEF00D, 5, 0, 1'b0, 1'b0, -1);
        do_txn(READ, 30'h2001, 32'h0, 32'h0BADF00D, 0, 1, 1'b0, 1'b0, -1);
        do_txn(WRITE, 30'h3FFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0, 1'b0, 1'b0, -1);
        idle(1);
        // ready in the last allowed WAIT cycle counts as success
        do_txn(READ, 30'h44, 32'h0, 32'hA5A5A5A5, 0, TO - 1, 1'b0, 1'b0, -1);
        idle(1);
        // spurious ready in ACCESS, grant dropped in WAIT
        do_txn(READ, 30'h55, 32'h0, 32'h5A5A5A5A, 1, 2, 1'b1, 1'b1, -1);
        idle(1);
        // slave never answers
        do_stuck(30'h66);
        idle(2);
        // reset in WAIT aborts without ack; next request completes normally
        do_txn(READ, 30'h77, 32'h0, 32'h11111111, 0, 5, 1'b0, 1'b0, 2);
        idle(1);
        do_txn(READ, 30'h78, 32'h0, 32'h22222222, 0, 0, 1'b0, 1'b0, -1);
        idle(1);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom), AW'($urandom), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 4),
                   1'($urandom), 1'($urandom), -1);
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_yutorina_bus_if
